huc_mem_arb: RTL

Arbiter and access sequencer for the single cartridge memory port of the HuC system. Shares the memory between the mapper's CPU-side requests (highest priority) and a DMA port used by the MCU for loading and backup. It generates fixed-length memory strobe cycles and latches read data for each requester. It sits between the mapper's ROM/RAM control outputs and the physical memory pins.

---
 rtl/huc_mem_arb_if.sv | 40 ++++
 rtl/huc_mem_arb.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/huc_mem_arb_if.sv
// Bundle of the CPU-side, DMA-side and memory-side buses of huc_mem_arb.
// master: the environment (mapper, MCU DMA, memory); slave: the arbiter.
interface huc_mem_arb_if;
   logic        cpu_ce;
   logic        cpu_oe;
   logic        cpu_we;
   logic [23:0] cpu_addr;
   logic [7:0]  cpu_dati;
   logic [7:0]  cpu_dato;
   logic        cpu_ovf;
   logic        dma_req;
   logic        dma_we;
   logic [23:0] dma_addr;
   logic [7:0]  dma_dati;
   logic        dma_ack;
   logic [7:0]  dma_dato;
   logic        mem_ce;
   logic        mem_oe;
   logic        mem_we;
   logic [23:0] mem_addr;
   logic [7:0]  mem_dati;
   logic [7:0]  mem_dato;
   logic        busy;

   modport master (
      output cpu_ce, cpu_oe, cpu_we, cpu_addr, cpu_dati,
      output dma_req, dma_we, dma_addr, dma_dati,
      output mem_dato,
      input  cpu_dato, cpu_ovf, dma_ack, dma_dato,
      input  mem_ce, mem_oe, mem_we, mem_addr, mem_dati, busy
   );

   modport slave (
      input  cpu_ce, cpu_oe, cpu_we, cpu_addr, cpu_dati,
      input  dma_req, dma_we, dma_addr, dma_dati,
      input  mem_dato,
      output cpu_dato, cpu_ovf, dma_ack, dma_dato,
      output mem_ce, mem_oe, mem_we, mem_addr, mem_dati, busy
   );
endinterface

// File: rtl/huc_mem_arb.sv
// Cartridge memory port arbiter: mapper CPU accesses (strict priority) and
// MCU DMA accesses share one memory, each as a fixed ACC_CYC strobe burst
// followed by one recovery cycle. All outputs come straight from flops.
module huc_mem_arb #(
   parameter int unsigned ACC_CYC = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   huc_mem_arb_if.slave bus
);

   typedef enum logic [1:0] {IDLE = 2'd0, CPU_ACC = 2'd1, DMA_ACC = 2'd2, REC = 2'd3} state_t;

   localparam logic [3:0] LAST_CNT = 4'(ACC_CYC - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [1:0]  hit_q, hit_d;          // [0] sampled strobe, [1] its delayed copy
   logic        cpu_pend_q, cpu_pend_d;
   logic        cap_we_q, cap_we_d;
   logic [23:0] cap_addr_q, cap_addr_d;
   logic [7:0]  cap_dati_q, cap_dati_d;
   logic        acc_dma_q, acc_dma_d;  // current/last access belongs to DMA
   logic        dma_armed_q, dma_armed_d;
   logic        mem_ce_q, mem_ce_d;
   logic        mem_oe_q, mem_oe_d;
   logic        mem_we_q, mem_we_d;
   logic [23:0] mem_addr_q, mem_addr_d;
   logic [7:0]  mem_dati_q, mem_dati_d;
   logic [7:0]  cpu_dato_q, cpu_dato_d;
   logic [7:0]  dma_dato_q, dma_dato_d;
   logic        dma_ack_q, dma_ack_d;
   logic        cpu_ovf_q, cpu_ovf_d;
   logic        busy_q, busy_d;

   logic        cpu_hit, cpu_evt, cpu_rise;

   // Next-state, capture and output computation
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cpu_pend_d  = cpu_pend_q;
      cap_we_d    = cap_we_q;
      cap_addr_d  = cap_addr_q;
      cap_dati_d  = cap_dati_q;
      acc_dma_d   = acc_dma_q;
      dma_armed_d = dma_armed_q;
      mem_ce_d    = mem_ce_q;
      mem_oe_d    = mem_oe_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_dati_d  = mem_dati_q;
      cpu_dato_d  = cpu_dato_q;
      dma_dato_d  = dma_dato_q;
      cpu_ovf_d   = cpu_ovf_q;
      dma_ack_d   = 1'b0;

      cpu_hit  = bus.cpu_ce & (bus.cpu_oe | bus.cpu_we);
      hit_d    = {hit_q[0], cpu_hit};
      cpu_evt  = hit_q[0] & ~hit_q[1];
      // A CPU edge anywhere in the detector holds off a DMA grant, so a DMA
      // request arriving together with a CPU strobe loses to the CPU.
      cpu_rise = (cpu_hit & ~hit_q[0]) | cpu_evt;

      if (!bus.dma_req) dma_armed_d = 1'b1;

      case (state_q)
         IDLE: begin
            if (cpu_pend_q) begin
               state_d    = CPU_ACC;
               cnt_d      = 4'd0;
               cpu_pend_d = 1'b0;
               acc_dma_d  = 1'b0;
               mem_ce_d   = 1'b1;
               mem_oe_d   = ~cap_we_q;
               mem_we_d   = cap_we_q;
               mem_addr_d = cap_addr_q;
               mem_dati_d = cap_dati_q;
            end else if (bus.dma_req && dma_armed_q && !cpu_rise) begin
               state_d     = DMA_ACC;
               cnt_d       = 4'd0;
               dma_armed_d = 1'b0;
               acc_dma_d   = 1'b1;
               mem_ce_d    = 1'b1;
               mem_oe_d    = ~bus.dma_we;
               mem_we_d    = bus.dma_we;
               mem_addr_d  = bus.dma_addr;
               mem_dati_d  = bus.dma_dati;
            end
         end
         CPU_ACC, DMA_ACC: begin
            if (cnt_q == LAST_CNT) begin
               state_d  = REC;
               mem_ce_d = 1'b0;
               mem_oe_d = 1'b0;
               mem_we_d = 1'b0;
               if (mem_oe_q) begin
                  if (acc_dma_q) dma_dato_d = bus.mem_dato;
                  else           cpu_dato_d = bus.mem_dato;
               end
               dma_ack_d = acc_dma_q;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         REC:     state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Capture after the IDLE decision so an event on the grant edge of a
      // CPU access is taken as the next access, not counted as lost.
      if (cpu_evt) begin
         if (cpu_pend_d) begin
            cpu_ovf_d = 1'b1;
         end else begin
            cpu_pend_d = 1'b1;
            cap_we_d   = bus.cpu_we;
            cap_addr_d = bus.cpu_addr;
            cap_dati_d = bus.cpu_dati;
         end
      end

      busy_d = (state_d != IDLE);
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         hit_q       <= 2'b00;
         cpu_pend_q  <= 1'b0;
         cap_we_q    <= 1'b0;
         cap_addr_q  <= 24'd0;
         cap_dati_q  <= 8'd0;
         acc_dma_q   <= 1'b0;
         dma_armed_q <= 1'b1;
         mem_ce_q    <= 1'b0;
         mem_oe_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 24'd0;
         mem_dati_q  <= 8'd0;
         cpu_dato_q  <= 8'd0;
         dma_dato_q  <= 8'd0;
         dma_ack_q   <= 1'b0;
         cpu_ovf_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         hit_q       <= hit_d;
         cpu_pend_q  <= cpu_pend_d;
         cap_we_q    <= cap_we_d;
         cap_addr_q  <= cap_addr_d;
         cap_dati_q  <= cap_dati_d;
         acc_dma_q   <= acc_dma_d;
         dma_armed_q <= dma_armed_d;
         mem_ce_q    <= mem_ce_d;
         mem_oe_q    <= mem_oe_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_dati_q  <= mem_dati_d;
         cpu_dato_q  <= cpu_dato_d;
         dma_dato_q  <= dma_dato_d;
         dma_ack_q   <= dma_ack_d;
         cpu_ovf_q   <= cpu_ovf_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.mem_ce   = mem_ce_q;
   assign bus.mem_oe   = mem_oe_q;
   assign bus.mem_we   = mem_we_q;
   assign bus.mem_addr = mem_addr_q;
   assign bus.mem_dati = mem_dati_q;
   assign bus.cpu_dato = cpu_dato_q;
   assign bus.dma_dato = dma_dato_q;
   assign bus.dma_ack  = dma_ack_q;
   assign bus.cpu_ovf  = cpu_ovf_q;
   assign bus.busy     = busy_q;

endmodule
